// File: rtl/int_exec_unit.sv
// Integer execute stage: ALU ops and branch conditions from RISC-V funct3, valid/ready on both sides.
// Shifts are iterative (1 bit/cycle) unless BARREL_SHIFT_EN is defined, which makes them single-cycle.
module int_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_br,
  input  logic [2:0]      req_funct3,
  input  logic            req_alt,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_taken,
  output logic            rsp_illegal,
  output logic [1:0]      dbg_state
);
  localparam int SHW = $clog2(XLEN);

  // Handshake: a request transfers on a cycle where req_valid && req_ready; a response
  // transfers on rsp_valid && rsp_ready, and rsp_* hold steady until then.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

  state_t          state, state_nx;
  logic            accept;
  logic            start_shift;
  logic            shift_last;
  logic [XLEN-1:0] shift_value;
  logic [XLEN-1:0] comb_result;
  logic            comb_taken;
  logic            comb_illegal;
  logic [SHW-1:0]  shamt;

  assign shamt     = req_b[SHW-1:0];
  assign rsp_valid = (state == S_DONE);
  assign dbg_state = state;

  // Single-cycle datapath: everything except a non-zero iterative shift
  always_comb begin
    comb_result  = '0;
    comb_taken   = 1'b0;
    comb_illegal = 1'b0;
    start_shift  = 1'b0;
    if (req_is_br) begin
      case (req_funct3)
        3'b000:  comb_taken = (req_a == req_b);
        3'b001:  comb_taken = (req_a != req_b);
        3'b100:  comb_taken = ($signed(req_a) <  $signed(req_b));
        3'b101:  comb_taken = ($signed(req_a) >= $signed(req_b));
        3'b110:  comb_taken = (req_a <  req_b);
        3'b111:  comb_taken = (req_a >= req_b);
        default: comb_illegal = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000: comb_result = req_alt ? (req_a - req_b) : (req_a + req_b);
`ifdef BARREL_SHIFT_EN
        3'b001: comb_result = req_a << shamt;
        3'b101: begin
          if (req_alt) comb_result = $signed(req_a) >>> shamt;
          else         comb_result = req_a >> shamt;
        end
`else
        3'b001, 3'b101: begin
          if (shamt == '0) comb_result = req_a;
          else             start_shift = 1'b1;
        end
`endif
        3'b010:  comb_result = {{(XLEN-1){1'b0}}, ($signed(req_a) < $signed(req_b))};
        3'b011:  comb_result = {{(XLEN-1){1'b0}}, (req_a < req_b)};
        3'b100:  comb_result = req_a ^ req_b;
        3'b110:  comb_result = req_a | req_b;
        default: comb_result = req_a & req_b;
      endcase
    end
  end

`ifdef BARREL_SHIFT_EN
  assign shift_last  = 1'b0;
  assign shift_value = '0;
`else
  logic [XLEN-1:0] acc;
  logic [SHW-1:0]  cnt;
  logic            sh_left;
  logic            sh_arith;

  assign shift_value = sh_left ? {acc[XLEN-2:0], 1'b0} : {sh_arith & acc[XLEN-1], acc[XLEN-1:1]};
  assign shift_last  = (state == S_SHIFT) && (cnt == SHW'(1));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      acc      <= '0;
      cnt      <= '0;
      sh_left  <= 1'b0;
      sh_arith <= 1'b0;
    end else if (accept && start_shift) begin
      acc      <= req_a;
      cnt      <= shamt;
      sh_left  <= (req_funct3 == 3'b001);
      sh_arith <= req_alt;
    end else if (state == S_SHIFT) begin
      acc <= shift_value;
      cnt <= cnt - SHW'(1);
    end
  end
`endif

  // Next state; DONE with rsp_ready behaves like IDLE so back-to-back ops need no bubble
  always_comb begin
    state_nx  = state;
    req_ready = !flush && ((state == S_IDLE) || ((state == S_DONE) && rsp_ready));
    accept    = req_valid && req_ready;
    case (state)
      S_IDLE:  state_nx = S_IDLE;
      S_SHIFT: if (shift_last) state_nx = S_DONE;
      S_DONE:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (accept) state_nx = start_shift ? S_SHIFT : S_DONE;
    if (flush)  state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rsp_result  <= '0;
      rsp_taken   <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept && !start_shift) begin
        rsp_result  <= comb_result;
        rsp_taken   <= comb_taken;
        rsp_illegal <= comb_illegal;
      end else if (shift_last && !flush) begin
        rsp_result  <= shift_value;
        rsp_taken   <= 1'b0;
        rsp_illegal <= 1'b0;
      end
    end
  end
endmodule
